rename_regfile: RTL and testbench
=================================

RENAME_REGFILE -- requirements
Module: rename_regfile

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width.
REQ-002 SHALL have parameter NREG, default 32, architectural register count; x0 included.
REQ-003 SHALL have parameter AW, default 5, register index width, equal to log2(NREG).
REQ-004 SHALL have parameter TAG_W, default 4, ROB tag width.
REQ-005 SHALL have one clock and an asynchronous, active-low reset.
REQ-006 SHALL provide port clk, input, 1, rising-edge clock.
REQ-007 SHALL provide port rst, input, 1, asynchronous active-low reset.
REQ-008 SHALL provide rename_valid, input, 1 and rename_ready, output, 1: decoder handshake.
REQ-009 SHALL provide rename_rs1, rename_rs2 and rename_rd, inputs, AW each: source and destination indices.
REQ-010 SHALL provide rename_tag, input, TAG_W: ROB tag allocated to rd.
REQ-011 SHALL provide commit_valid, input, 1; commit_rd, input, AW; commit_tag, input, TAG_W; commit_data, input, XLEN: ROB retire port.
REQ-012 SHALL provide flush, input, 1: exception or mispredict recovery.
REQ-013 SHALL provide out_valid, output, 1 and out_ready, input, 1: issue handshake.
REQ-014 SHALL provide out_v1 and out_v2, outputs, XLEN each: operand values.
REQ-015 SHALL provide out_b1 and out_b2, outputs, 1 each: operand pending, meaning the matching out_q is valid.
REQ-016 SHALL provide out_q1 and out_q2, outputs, TAG_W each: producer tags.

Function
REQ-017 SHALL keep, per register, a value, a busy bit and a tag; x0 SHALL always read value 0 with busy 0.
REQ-018 SHALL drive rename_ready = !out_valid || out_ready.
REQ-019 SHALL accept a rename when rename_valid && rename_ready && !flush.
REQ-020 SHALL, on accept, register the source reads into the out_* registers and set out_valid the next cycle: latency 1.
REQ-021 SHALL read sources from the pre-rename state, so rs == rd returns the old mapping.
REQ-022 SHALL, on accept with rd != 0, set busy[rd]=1 and tag[rd]=rename_tag at the clock edge.
REQ-023 SHALL, on commit with rd != 0, write value[rd]=commit_data.
REQ-024 SHALL, on commit, clear busy[rd] only when tag[rd]==commit_tag and the same-cycle rename does not target rd.
REQ-025 SHALL bypass a same-cycle commit into an accepted source when rs==commit_rd, busy[rs]=1 and tag matches: out_b=0 and out_v=commit_data.
REQ-026 SHALL snoop commits while out_valid && !out_ready: when out_bX=1 and out_qX==commit_tag, set out_bX=0 and out_vX=commit_data; all other outputs SHALL stay stable.
REQ-027 SHALL clear out_valid on out_ready when no new accept occurs.
REQ-028 SHALL, on flush, clear all busy bits and out_valid, and ignore rename.
REQ-029 SHALL still write value on a commit coincident with flush.

Reset
REQ-030 SHALL, while rst=0, zero every value, busy bit and tag, force out_valid=0 and drive all out_* to 0.
REQ-031 SHALL have rename_ready=1 after reset.
REQ-032 SHALL abandon any held output on reset mid-operation.

Structure
REQ-033 SHALL place XLEN, AW, TAG_W defaults and the operand struct {v, b, q} in the shared parameters package.
REQ-034 SHALL implement the per-source read, bypass and snoop logic as sub-module rf_src_read, instanced twice.

Verification
REQ-035 SHALL cover reset then rename rs1=0, rs2=0, rd=5, tag=3 -> next cycle out_valid=1, b1=b2=0, v1=v2=0; busy[5]=1.
REQ-036 SHALL cover a following rename rs1=5, tag=4 -> out_b1=1, out_q1=3.
REQ-037 SHALL cover commit rd=5, tag=3, data=0x1234 in the same cycle as rename rs1=5 -> out_b1=0, out_v1=0x1234.
REQ-038 SHALL cover out_ready=0 with held b1=1, q1=3, then commit tag 3 data 0xAA -> b1=0, v1=0xAA with valid held.
REQ-039 SHALL cover rename rd=5, tag=7 in the same cycle as commit rd=5, tag=3 -> busy[5]=1 with tag 7 and value updated.
REQ-040 SHALL cover flush with busy regs and pending output -> out_valid=0, all busy clear, next reads b=0.

Source files
------------

// File: rtl/rename_regfile_pkg.sv
// rename_regfile_pkg: shared widths and operand record for the rename register file
package rename_regfile_pkg;
   localparam int XLEN_DEF  = 32;
   localparam int NREG_DEF  = 32;
   localparam int AW_DEF    = 5;
   localparam int TAG_W_DEF = 4;

   typedef struct packed {
      logic [XLEN_DEF-1:0]  v;
      logic                 b;
      logic [TAG_W_DEF-1:0] q;
   } operand_t;
endpackage

// File: rtl/rename_regfile_rf_src_read.sv
// rf_src_read: one issued operand register with same-cycle commit bypass and held-output snoop
module rf_src_read
   import rename_regfile_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int AW    = AW_DEF,
   parameter int TAG_W = TAG_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             hold,
   input  logic [AW-1:0]    rs,
   input  logic [XLEN-1:0]  rf_v,
   input  logic             rf_b,
   input  logic [TAG_W-1:0] rf_q,
   input  logic             commit_valid,
   input  logic [AW-1:0]    commit_rd,
   input  logic [TAG_W-1:0] commit_tag,
   input  logic [XLEN-1:0]  commit_data,
   output logic [XLEN-1:0]  v,
   output logic             b,
   output logic [TAG_W-1:0] q
);
   logic byp, snp;

   assign byp = commit_valid && rs == commit_rd && rf_b && rf_q == commit_tag;
   // a stalled operand still wakes up when its producer retires
   assign snp = hold && b && commit_valid && q == commit_tag;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v <= '0;
         b <= 1'b0;
         q <= '0;
      end else if (load) begin
         v <= byp ? commit_data : rf_v;
         b <= rf_b && !byp;
         q <= rf_q;
      end else if (snp) begin
         v <= commit_data;
         b <= 1'b0;
      end
   end
endmodule

// File: rtl/rename_regfile.sv
// rename_regfile: architectural value/busy/tag file with rename, ROB commit and a registered issue port
module rename_regfile
   import rename_regfile_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int NREG  = NREG_DEF,
   parameter int AW    = AW_DEF,
   parameter int TAG_W = TAG_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rename_valid,
   output logic             rename_ready,
   input  logic [AW-1:0]    rename_rs1,
   input  logic [AW-1:0]    rename_rs2,
   input  logic [AW-1:0]    rename_rd,
   input  logic [TAG_W-1:0] rename_tag,
   input  logic             commit_valid,
   input  logic [AW-1:0]    commit_rd,
   input  logic [TAG_W-1:0] commit_tag,
   input  logic [XLEN-1:0]  commit_data,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_v1,
   output logic [XLEN-1:0]  out_v2,
   output logic             out_b1,
   output logic             out_b2,
   output logic [TAG_W-1:0] out_q1,
   output logic [TAG_W-1:0] out_q2
);
   logic [XLEN-1:0]  val [NREG];
   logic [TAG_W-1:0] tag [NREG];
   logic [NREG-1:0]  busy;
   logic             accept, hold, commit_wr;

   assign rename_ready = !out_valid || out_ready;
   assign accept       = rename_valid && rename_ready && !flush;
   assign hold         = out_valid && !out_ready;
   assign commit_wr    = commit_valid && commit_rd != '0;

   // entry 0 is never written, so x0 reads 0 / not busy without special-casing
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy <= '0;
         for (int i = 0; i < NREG; i++) begin
            val[i] <= '0;
            tag[i] <= '0;
         end
      end else begin
         if (commit_wr) val[commit_rd] <= commit_data;
         if (flush) busy <= '0;
         else begin
            if (commit_wr && tag[commit_rd] == commit_tag && !(accept && rename_rd == commit_rd))
               busy[commit_rd] <= 1'b0;
            if (accept && rename_rd != '0) begin
               busy[rename_rd] <= 1'b1;
               tag[rename_rd]  <= rename_tag;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) out_valid <= 1'b0;
      else if (flush) out_valid <= 1'b0;
      else if (accept) out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
   end

   rf_src_read #(.XLEN(XLEN), .AW(AW), .TAG_W(TAG_W)) u_src1 (
      .clk(clk), .rst(rst), .load(accept), .hold(hold), .rs(rename_rs1),
      .rf_v(val[rename_rs1]), .rf_b(busy[rename_rs1]), .rf_q(tag[rename_rs1]),
      .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_tag(commit_tag),
      .commit_data(commit_data), .v(out_v1), .b(out_b1), .q(out_q1)
   );

   rf_src_read #(.XLEN(XLEN), .AW(AW), .TAG_W(TAG_W)) u_src2 (
      .clk(clk), .rst(rst), .load(accept), .hold(hold), .rs(rename_rs2),
      .rf_v(val[rename_rs2]), .rf_b(busy[rename_rs2]), .rf_q(tag[rename_rs2]),
      .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_tag(commit_tag),
      .commit_data(commit_data), .v(out_v2), .b(out_b2), .q(out_q2)
   );
endmodule

// File: tb/tb_rename_regfile.sv
// tb_rename_regfile: directed rename/commit/snoop/flush/reset vectors with hand-computed expectations
module tb_rename_regfile;
   import rename_regfile_pkg::*;

   logic                 clk = 1'b0, rst = 1'b0;
   logic                 rename_valid = 1'b0, rename_ready;
   logic [AW_DEF-1:0]    rename_rs1 = '0, rename_rs2 = '0, rename_rd = '0;
   logic [TAG_W_DEF-1:0] rename_tag = '0;
   logic                 commit_valid = 1'b0;
   logic [AW_DEF-1:0]    commit_rd = '0;
   logic [TAG_W_DEF-1:0] commit_tag = '0;
   logic [XLEN_DEF-1:0]  commit_data = '0;
   logic                 flush = 1'b0, out_valid, out_ready = 1'b1;
   logic [XLEN_DEF-1:0]  out_v1, out_v2;
   logic                 out_b1, out_b2;
   logic [TAG_W_DEF-1:0] out_q1, out_q2;
   int                   n_checks = 0, n_fail = 0;

   rename_regfile dut (
      .clk(clk), .rst(rst), .rename_valid(rename_valid), .rename_ready(rename_ready),
      .rename_rs1(rename_rs1), .rename_rs2(rename_rs2), .rename_rd(rename_rd),
      .rename_tag(rename_tag), .commit_valid(commit_valid), .commit_rd(commit_rd),
      .commit_tag(commit_tag), .commit_data(commit_data), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_v1(out_v1), .out_v2(out_v2),
      .out_b1(out_b1), .out_b2(out_b2), .out_q1(out_q1), .out_q2(out_q2)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic ren(input logic v, input int rs1, input int rs2, input int rd, input int tg);
      rename_valid = v;
      rename_rs1   = AW_DEF'(rs1);
      rename_rs2   = AW_DEF'(rs2);
      rename_rd    = AW_DEF'(rd);
      rename_tag   = TAG_W_DEF'(tg);
   endtask

   task automatic com(input logic v, input int rd, input int tg, input logic [31:0] d);
      commit_valid = v;
      commit_rd    = AW_DEF'(rd);
      commit_tag   = TAG_W_DEF'(tg);
      commit_data  = d;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #12;
      check("rst_valid", out_valid, 0);
      check("rst_ready", rename_ready, 1);
      check("rst_v1", out_v1, 0);
      check("rst_q2", out_q2, 0);
      rst = 1'b1;
      step();
      ren(1, 0, 0, 5, 3); step();
      check("t1_valid", out_valid, 1);
      check("t1_b1", out_b1, 0);
      check("t1_b2", out_b2, 0);
      check("t1_v1", out_v1, 0);
      check("t1_v2", out_v2, 0);
      ren(1, 5, 0, 6, 4); step();
      check("t2_b1", out_b1, 1);
      check("t2_q1", out_q1, 3);
      check("t2_b2", out_b2, 0);
      ren(1, 5, 6, 7, 5); com(1, 5, 3, 32'h1234); step();
      check("t3_byp_b1", out_b1, 0);
      check("t3_byp_v1", out_v1, 32'h1234);
      check("t3_b2", out_b2, 1);
      check("t3_q2", out_q2, 4);
      ren(1, 0, 0, 5, 3); com(0, 0, 0, 0); step();
      ren(1, 5, 7, 0, 0); step();
      check("t5_b1", out_b1, 1);
      check("t5_q1", out_q1, 3);
      check("t5_q2", out_q2, 5);
      ren(0, 0, 0, 0, 0); out_ready = 1'b0; step();
      check("t6_hold_valid", out_valid, 1);
      check("t6_hold_b1", out_b1, 1);
      check("t6_ready", rename_ready, 0);
      ren(1, 0, 0, 9, 9); com(1, 5, 3, 32'hAA); step();
      check("t7_snoop_valid", out_valid, 1);
      check("t7_snoop_b1", out_b1, 0);
      check("t7_snoop_v1", out_v1, 32'hAA);
      check("t7_keep_b2", out_b2, 1);
      check("t7_keep_q2", out_q2, 5);
      ren(0, 0, 0, 0, 0); com(0, 0, 0, 0); out_ready = 1'b1; step();
      check("t8_drain", out_valid, 0);
      ren(1, 0, 0, 5, 3); step();
      ren(1, 9, 5, 5, 7); com(1, 5, 3, 32'h55); step();
      check("t10_ignored_b1", out_b1, 0);
      check("t10_ignored_v1", out_v1, 0);
      check("t10_byp_b2", out_b2, 0);
      check("t10_byp_v2", out_v2, 32'h55);
      ren(1, 5, 0, 0, 0); com(0, 0, 0, 0); step();
      check("t11_newtag_b1", out_b1, 1);
      check("t11_newtag_q1", out_q1, 7);
      ren(1, 0, 0, 8, 2); com(1, 7, 0, 32'h99); flush = 1'b1; out_ready = 1'b0; step();
      check("t12_flush_valid", out_valid, 0);
      check("t12_flush_ready", rename_ready, 1);
      ren(1, 5, 7, 5, 1); com(0, 0, 0, 0); flush = 1'b0; out_ready = 1'b1; step();
      check("t13_b1", out_b1, 0);
      check("t13_v1", out_v1, 32'h55);
      check("t13_b2", out_b2, 0);
      check("t13_v2", out_v2, 32'h99);
      ren(1, 8, 5, 0, 0); step();
      check("t14_b1", out_b1, 0);
      check("t14_v1", out_v1, 0);
      check("t14_b2", out_b2, 1);
      check("t14_q2", out_q2, 1);
      ren(1, 0, 5, 0, 0); out_ready = 1'b0; step();
      check("t15_b2", out_b2, 1);
      #2 rst = 1'b0;
      #1;
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_b2", out_b2, 0);
      check("mid_rst_q2", out_q2, 0);
      check("mid_rst_ready", rename_ready, 1);
      #1 rst = 1'b1;
      out_ready = 1'b1; step();
      check("t16_valid", out_valid, 1);
      check("t16_b2", out_b2, 0);
      check("t16_v2", out_v2, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
